// File: rtl/frame_uart_streamer.sv
// Debounced trigger dumps a WIDTH x HEIGHT buffer in raster order as SYNC0, SYNC1, pixels.
// Optional xor checksum byte (FRAME_STREAM_CSUM_EN); each byte waits for HOLDOFF idle UART cycles.
module frame_uart_streamer #(
  parameter int          WIDTH         = 40,
  parameter int          HEIGHT        = 30,
  parameter int          XW            = 6,
  parameter int          YW            = 5,
  parameter int          READ_LAT      = 1,
  parameter int          HOLDOFF       = 8191,
  parameter int          DEBOUNCE_BITS = 14,
  parameter logic [7:0]  SYNC0         = 8'hFF,
  parameter logic [7:0]  SYNC1         = 8'h00
) (
  input  logic          clk,
  input  logic          areset_n,
  input  logic          trigger,
  input  logic          continuous,
  output logic [XW-1:0] read_x,
  output logic [YW-1:0] read_y,
  input  logic [7:0]    read_q,
  input  logic          uart_busy,
  output logic          uart_write,
  output logic [7:0]    uart_data,
  output logic          busy,
  output logic          frame_done
);
  localparam int HW = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR0, S_HDR1, S_FETCH, S_WAIT, S_SEND, S_TAIL, S_DONE
  } state_t;

  state_t                   state, state_nxt;
  logic                     trig_s1, trig_s2, deb_lvl, deb_lvl_d;
  logic [DEBOUNCE_BITS-1:0] deb_cnt;
  logic [HW-1:0]            hold_cnt;
  logic [1:0]               lat_cnt, lat_nxt;
  logic [7:0]               pix, pix_nxt, dat_nxt;
  logic [XW-1:0]            x_nxt;
  logic [YW-1:0]            y_nxt;
  logic                     wr_nxt, start, ready;
`ifdef FRAME_STREAM_CSUM_EN
  logic [7:0]               csum;
`endif

  // Counter only runs while the synchronised level disagrees with the debounced one.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      trig_s1   <= 1'b0;
      trig_s2   <= 1'b0;
      deb_lvl   <= 1'b0;
      deb_lvl_d <= 1'b0;
      deb_cnt   <= '0;
    end else begin
      trig_s1   <= trigger;
      trig_s2   <= trig_s1;
      deb_lvl_d <= deb_lvl;
      if (trig_s2 == deb_lvl) begin
        deb_cnt <= '0;
      end else if (&deb_cnt) begin
        deb_lvl <= trig_s2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  assign start = deb_lvl & ~deb_lvl_d;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      hold_cnt <= '0;
    end else if (uart_busy || uart_write) begin
      hold_cnt <= '0;
    end else if (hold_cnt != HW'(HOLDOFF)) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

  assign ready = (hold_cnt == HW'(HOLDOFF)) && !uart_busy && !uart_write;

  always_comb begin
    state_nxt = state;
    wr_nxt    = 1'b0;
    dat_nxt   = uart_data;
    x_nxt     = read_x;
    y_nxt     = read_y;
    lat_nxt   = lat_cnt;
    pix_nxt   = pix;
    case (state)
      S_IDLE: if (start) begin
        state_nxt = S_HDR0;
        x_nxt     = '0;
        y_nxt     = '0;
      end
      S_HDR0: if (ready) begin
        wr_nxt    = 1'b1;
        dat_nxt   = SYNC0;
        state_nxt = S_HDR1;
      end
      S_HDR1: if (ready) begin
        wr_nxt    = 1'b1;
        dat_nxt   = SYNC1;
        state_nxt = S_FETCH;
      end
      S_FETCH: begin
        lat_nxt   = 2'(READ_LAT);
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        lat_nxt = lat_cnt - 1'b1;
        if (lat_cnt == 2'd1) begin
          pix_nxt   = read_q;
          state_nxt = S_SEND;
        end
      end
      // Address advances together with the strobe so it is settled before the next fetch.
      S_SEND: if (ready) begin
        wr_nxt    = 1'b1;
        dat_nxt   = pix;
        state_nxt = S_FETCH;
        if (read_x == XW'(WIDTH - 1)) begin
          x_nxt = '0;
          if (read_y == YW'(HEIGHT - 1)) begin
            y_nxt     = '0;
            state_nxt = S_TAIL;
          end else begin
            y_nxt = read_y + 1'b1;
          end
        end else begin
          x_nxt = read_x + 1'b1;
        end
      end
`ifdef FRAME_STREAM_CSUM_EN
      S_TAIL: if (ready) begin
        wr_nxt    = 1'b1;
        dat_nxt   = csum;
        state_nxt = S_DONE;
      end
`else
      S_TAIL: state_nxt = S_DONE;
`endif
      S_DONE:  state_nxt = continuous ? S_HDR0 : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state      <= S_IDLE;
      uart_write <= 1'b0;
      uart_data  <= 8'h00;
      read_x     <= '0;
      read_y     <= '0;
      lat_cnt    <= '0;
      pix        <= 8'h00;
    end else begin
      state      <= state_nxt;
      uart_write <= wr_nxt;
      uart_data  <= dat_nxt;
      read_x     <= x_nxt;
      read_y     <= y_nxt;
      lat_cnt    <= lat_nxt;
      pix        <= pix_nxt;
    end
  end

`ifdef FRAME_STREAM_CSUM_EN
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      csum <= 8'h00;
    end else if (state == S_HDR0) begin
      csum <= 8'h00;
    end else if (state == S_SEND && ready) begin
      csum <= csum ^ pix;
    end
  end
`endif

  assign busy       = (state != S_IDLE);
  assign frame_done = (state == S_DONE);

endmodule

// File: tb/tb_frame_uart_streamer.sv
// Drives two streamers (read latency 1 and 3) with shared stimulus and checks the byte streams
// against a frame-level reference built from the buffer contents.
module tb_frame_uart_streamer;
  localparam int W = 4, H = 2, HOLD = 3, DB = 2, NPIX = W * H;
`ifdef FRAME_STREAM_CSUM_EN
  localparam int FLEN = NPIX + 3;
`else
  localparam int FLEN = NPIX + 2;
`endif

  logic clk = 1'b0, areset_n = 1'b0, trigger = 1'b0, continuous = 1'b0;
  always #5 clk = ~clk;

  logic [5:0] rx0, rx1;
  logic [4:0] ry0, ry1;
  logic [7:0] rq0, rq1, ud0, ud1;
  logic       ub0, ub1, uw0, uw1, bz0, bz1, fd0, fd1;

  logic [7:0] mem [NPIX];
  logic [7:0] p0;
  logic [7:0] p1 [3];
  int busy_len = 10;
  int bc0 = 0, bc1 = 0;
  int cyc = 0;
  int vectors = 0, miscompares = 0;

  logic [7:0] got0[$], got1[$], exp_q[$];
  int done0 = 0, done1 = 0, viol0 = 0, viol1 = 0;
  int last0 = -1000, last1 = -1000;
  int base0, base1, dbase0, dbase1;

  frame_uart_streamer #(.WIDTH(W), .HEIGHT(H), .XW(6), .YW(5), .READ_LAT(1),
                        .HOLDOFF(HOLD), .DEBOUNCE_BITS(DB)) dut0 (
    .clk(clk), .areset_n(areset_n), .trigger(trigger), .continuous(continuous),
    .read_x(rx0), .read_y(ry0), .read_q(rq0), .uart_busy(ub0), .uart_write(uw0),
    .uart_data(ud0), .busy(bz0), .frame_done(fd0));

  frame_uart_streamer #(.WIDTH(W), .HEIGHT(H), .XW(6), .YW(5), .READ_LAT(3),
                        .HOLDOFF(HOLD), .DEBOUNCE_BITS(DB)) dut1 (
    .clk(clk), .areset_n(areset_n), .trigger(trigger), .continuous(continuous),
    .read_x(rx1), .read_y(ry1), .read_q(rq1), .uart_busy(ub1), .uart_write(uw1),
    .uart_data(ud1), .busy(bz1), .frame_done(fd1));

  // synchronous-read buffer with 1 and 3 cycles of latency
  always @(posedge clk) begin
    p0    <= mem[int'(ry0) * W + int'(rx0)];
    p1[0] <= mem[int'(ry1) * W + int'(rx1)];
    p1[1] <= p1[0];
    p1[2] <= p1[1];
  end
  assign rq0 = p0;
  assign rq1 = p1[2];

  // UART: busy for busy_len cycles after each strobe
  always @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      bc0 <= 0;
      bc1 <= 0;
    end else begin
      if (uw0) bc0 <= busy_len; else if (bc0 > 0) bc0 <= bc0 - 1;
      if (uw1) bc1 <= busy_len; else if (bc1 > 0) bc1 <= bc1 - 1;
    end
  end
  assign ub0 = (bc0 != 0);
  assign ub1 = (bc1 != 0);

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (uw0) begin
      got0.push_back(ud0);
      if (ub0 || (cyc - last0) < busy_len + HOLD + 1) viol0++;
      last0 = cyc;
    end
    if (uw1) begin
      got1.push_back(ud1);
      if (ub1 || (cyc - last1) < busy_len + HOLD + 1) viol1++;
      last1 = cyc;
    end
    if (fd0) done0++;
    if (fd1) done1++;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic fill_mem(input bit rnd);
    for (int i = 0; i < NPIX; i++) mem[i] = rnd ? 8'($urandom) : 8'(8'h10 + i);
  endtask

  // reference frame: header, raster pixels, optional xor of the pixels
  task automatic build_exp();
    logic [7:0] x;
    x = 8'h00;
    exp_q.delete();
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h00);
    for (int y = 0; y < H; y++)
      for (int c = 0; c < W; c++) begin
        exp_q.push_back(mem[y * W + c]);
        x = x ^ mem[y * W + c];
      end
`ifdef FRAME_STREAM_CSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  task automatic mark();
    base0 = got0.size(); base1 = got1.size();
    dbase0 = done0;      dbase1 = done1;
  endtask

  task automatic pulse_trigger(input int len);
    @(negedge clk) trigger = 1'b1;
    repeat (len) @(negedge clk);
    trigger = 1'b0;
  endtask

  task automatic wait_done(input int target, input int limit);
    int t = 0;
    while ((done0 - dbase0 < target || done1 - dbase1 < target) && t < limit) begin
      @(negedge clk);
      t++;
    end
    check_eq("done_wait_in_budget", 32'(t < limit), 1);
  endtask

  task automatic wait_strobes(input int n, input int limit);
    int t = 0;
    while ((got0.size() - base0 < n || got1.size() - base1 < n) && t < limit) begin
      @(negedge clk);
      t++;
    end
    check_eq("strobe_wait_in_budget", 32'(t < limit), 1);
  endtask

  task automatic cmp_stream(input string tag, input int nf);
    check_eq({tag, "_len_lat1"}, got0.size() - base0, nf * FLEN);
    check_eq({tag, "_len_lat3"}, got1.size() - base1, nf * FLEN);
    for (int f = 0; f < nf; f++)
      for (int i = 0; i < FLEN; i++) begin
        int k0 = base0 + f * FLEN + i;
        int k1 = base1 + f * FLEN + i;
        check_eq({tag, "_byte_lat1"}, (k0 < got0.size()) ? got0[k0] : 32'hBAD, exp_q[i]);
        check_eq({tag, "_byte_lat3"}, (k1 < got1.size()) ? got1[k1] : 32'hBAD, exp_q[i]);
      end
    check_eq({tag, "_done_lat1"}, done0 - dbase0, nf);
    check_eq({tag, "_done_lat3"}, done1 - dbase1, nf);
    check_eq({tag, "_spacing_lat1"}, viol0, 0);
    check_eq({tag, "_spacing_lat3"}, viol1, 0);
    check_eq({tag, "_idle_lat1"}, bz0, 0);
    check_eq({tag, "_idle_lat3"}, bz1, 0);
  endtask

  initial begin
    fill_mem(1'b0);
    repeat (3) @(negedge clk);
    check_eq("rst_busy", bz0, 0);
    check_eq("rst_write", uw0, 0);
    check_eq("rst_data", ud0, 0);
    check_eq("rst_x", rx0, 0);
    check_eq("rst_y", ry0, 0);
    check_eq("rst_done", fd0, 0);
    check_eq("rst_busy_lat3", bz1, 0);
    areset_n = 1'b1;
    repeat (5) @(negedge clk);

    // single frame with the linear test pattern
    build_exp();
    mark();
    pulse_trigger(20);
    wait_done(1, 3000);
    repeat (50) @(negedge clk);
    cmp_stream("single", 1);

    // short glitches must not start a frame
    mark();
    for (int g = 0; g < 4; g++) begin
      pulse_trigger($urandom_range(1, 3));
      repeat (20) @(negedge clk);
    end
    check_eq("glitch_no_bytes", got0.size() - base0, 0);
    check_eq("glitch_busy", bz0, 0);

    // retrigger while busy is ignored
    fill_mem(1'b1);
    busy_len = $urandom_range(2, 12);
    build_exp();
    mark();
    pulse_trigger(20);
    wait_strobes(3, 2000);
    pulse_trigger(20);
    wait_done(1, 5000);
    repeat (300) @(negedge clk);
    cmp_stream("retrig", 1);

    // continuous: two frames, mode dropped during frame 2
    fill_mem(1'b1);
    busy_len = $urandom_range(2, 12);
    build_exp();
    mark();
    continuous = 1'b1;
    pulse_trigger(20);
    wait_strobes(FLEN + 3, 8000);
    continuous = 1'b0;
    wait_done(2, 8000);
    repeat (300) @(negedge clk);
    cmp_stream("contin", 2);

    // reset in the middle of the pixels
    fill_mem(1'b1);
    busy_len = 10;
    mark();
    pulse_trigger(20);
    wait_strobes(6, 3000);
    repeat ($urandom_range(0, 4)) @(negedge clk);
    areset_n = 1'b0;
    #1;
    check_eq("midrst_write", uw0, 0);
    check_eq("midrst_busy", bz0, 0);
    check_eq("midrst_x", rx0, 0);
    check_eq("midrst_y", ry0, 0);
    check_eq("midrst_write_lat3", uw1, 0);
    check_eq("midrst_busy_lat3", bz1, 0);
    check_eq("midrst_x_lat3", rx1, 0);
    check_eq("midrst_y_lat3", ry1, 0);
    repeat (3) @(negedge clk);
    areset_n = 1'b1;
    mark();
    repeat (200) @(negedge clk);
    check_eq("postrst_quiet", got0.size() - base0, 0);
    check_eq("postrst_quiet_lat3", got1.size() - base1, 0);
    check_eq("postrst_busy", bz0, 0);

    // fresh trigger after reset streams a full frame again
    build_exp();
    mark();
    pulse_trigger(20);
    wait_done(1, 3000);
    repeat (50) @(negedge clk);
    cmp_stream("after_rst", 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
